// File: rtl/boot_word_feeder_pkg.sv
// rtl/boot_word_feeder_pkg.sv - shared state encodings, pad default and byte-lane helpers
// Used by boot_word_feeder and boot_byte_packer.
package boot_word_feeder_pkg;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_RST   = 3'd1,
    ST_FILL  = 3'd2,
    ST_REQ   = 3'd3,
    ST_ACKLO = 3'd4,
    ST_DONE  = 3'd5,
    ST_ERR   = 3'd6
  } boot_state_e;

  localparam logic [7:0] BOOT_PAD_DEFAULT = 8'hFF;

  // Big-endian lane order: the first byte of a word lands in [31:24].
  localparam logic [1:0] LANE_FIRST = 2'd0;
  localparam logic [1:0] LANE_LAST  = 2'd3;

  function automatic logic [31:0] lane_insert(input logic [31:0] w,
                                              input logic [1:0]  lane,
                                              input logic [7:0]  b);
    logic [31:0] r;
    r = w;
    case (lane)
      2'd0:    r[31:24] = b;
      2'd1:    r[23:16] = b;
      2'd2:    r[15:8]  = b;
      default: r[7:0]   = b;
    endcase
    return r;
  endfunction

endpackage

// File: rtl/boot_byte_packer.sv
// rtl/boot_byte_packer.sv - packs bytes into a big-endian 32-bit word with pad fill
// A word starts pre-filled with PAD_BYTE so a short final word needs no extra fill step.
module boot_byte_packer
  import boot_word_feeder_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = BOOT_PAD_DEFAULT
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        clear_i,
  input  logic        push_i,
  input  logic        last_i,
  input  logic [7:0]  byte_i,
  output logic [31:0] word_o,
  output logic        word_end_o
);

  logic [1:0]  lane_q, lane_d;
  logic [31:0] word_q, word_d;
  logic [31:0] base;

  always_comb begin
    lane_d     = lane_q;
    word_d     = word_q;
    base       = word_q;
    word_end_o = push_i && ((lane_q == LANE_LAST) || last_i);
    if (clear_i) begin
      lane_d = LANE_FIRST;
    end else if (push_i) begin
      if (lane_q == LANE_FIRST) begin
        base = {4{PAD_BYTE}};
      end
      word_d = lane_insert(base, lane_q, byte_i);
      lane_d = word_end_o ? LANE_FIRST : lane_q + 2'd1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      lane_q <= LANE_FIRST;
      word_q <= 32'h0;
    end else begin
      lane_q <= lane_d;
      word_q <= word_d;
    end
  end

  assign word_o = word_q;

endmodule

// File: rtl/boot_word_feeder.sv
// rtl/boot_word_feeder.sv - byte stream to 32-bit word feeder with req/ack handshake
// Optional BOOT_FEEDER_CHECKSUM_EN adds a 16-bit sum of accepted bytes on checksum.
module boot_word_feeder
  import boot_word_feeder_pkg::*;
#(
  parameter int         RST_CYCLES = 4,
  parameter logic [7:0] PAD_BYTE   = BOOT_PAD_DEFAULT,
  parameter int         ACK_TMO    = 1023
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [15:0] start_size,
  input  logic        start_chr,
  input  logic [7:0]  in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] host_bootdata,
  output logic        host_bootdata_req,
  input  logic        host_bootdata_ack,
  output logic        host_bootdata_reset,
  output logic [15:0] host_bootdata_size,
  output logic        loadchr,
  output logic        busy,
  output logic        done,
  output logic        error
`ifdef BOOT_FEEDER_CHECKSUM_EN
  ,output logic [15:0] checksum
`endif
);

  localparam logic [15:0] RST_LAST = 16'(RST_CYCLES - 1);
  localparam logic [15:0] TMO_LAST = 16'(ACK_TMO - 1);

  boot_state_e state_q, state_d;
  logic [15:0] rst_cnt_q, rst_cnt_d;
  logic [15:0] byte_cnt_q, byte_cnt_d;
  logic [15:0] size_q, size_d;
  logic        chr_q, chr_d;
  logic [15:0] tmo_cnt_q, tmo_cnt_d;

  logic        pk_clear, pk_push, pk_last, pk_word_end;
  logic        tmo_hit;
  logic [31:0] pk_word;

  boot_byte_packer #(.PAD_BYTE(PAD_BYTE)) u_packer (
    .clk        (clk),
    .rst_n      (rst_n),
    .clear_i    (pk_clear),
    .push_i     (pk_push),
    .last_i     (pk_last),
    .byte_i     (in_data),
    .word_o     (pk_word),
    .word_end_o (pk_word_end)
  );

  assign pk_last = ((byte_cnt_q + 16'd1) == size_q);
  assign tmo_hit = (ACK_TMO != 0) && (tmo_cnt_q == TMO_LAST);

  always_comb begin
    state_d    = state_q;
    rst_cnt_d  = rst_cnt_q;
    byte_cnt_d = byte_cnt_q;
    size_d     = size_q;
    chr_d      = chr_q;
    tmo_cnt_d  = tmo_cnt_q;
    in_ready   = 1'b0;
    pk_clear   = 1'b0;
    pk_push    = 1'b0;
    case (state_q)
      ST_IDLE, ST_DONE, ST_ERR: begin
        if (start) begin
          size_d     = start_size;
          chr_d      = start_chr;
          byte_cnt_d = 16'd0;
          rst_cnt_d  = 16'd0;
          tmo_cnt_d  = 16'd0;
          pk_clear   = 1'b1;
          state_d    = ST_RST;
        end
      end
      ST_RST: begin
        rst_cnt_d = rst_cnt_q + 16'd1;
        if (rst_cnt_q == RST_LAST) begin
          state_d = (size_q == 16'd0) ? ST_DONE : ST_FILL;
        end
      end
      ST_FILL: begin
        in_ready = 1'b1;
        if (in_valid) begin
          pk_push    = 1'b1;
          byte_cnt_d = byte_cnt_q + 16'd1;
          if (pk_word_end) begin
            tmo_cnt_d = 16'd0;
            state_d   = ST_REQ;
          end
        end
      end
      ST_REQ: begin
        // An ack already high on entry counts as the rising edge.
        if (host_bootdata_ack) begin
          tmo_cnt_d = 16'd0;
          state_d   = ST_ACKLO;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      ST_ACKLO: begin
        if (!host_bootdata_ack) begin
          state_d = (byte_cnt_q == size_q) ? ST_DONE : ST_FILL;
        end else if (tmo_hit) begin
          state_d = ST_ERR;
        end else begin
          tmo_cnt_d = tmo_cnt_q + 16'd1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= ST_IDLE;
      rst_cnt_q  <= 16'd0;
      byte_cnt_q <= 16'd0;
      size_q     <= 16'd0;
      chr_q      <= 1'b0;
      tmo_cnt_q  <= 16'd0;
    end else begin
      state_q    <= state_d;
      rst_cnt_q  <= rst_cnt_d;
      byte_cnt_q <= byte_cnt_d;
      size_q     <= size_d;
      chr_q      <= chr_d;
      tmo_cnt_q  <= tmo_cnt_d;
    end
  end

  assign host_bootdata       = pk_word;
  assign host_bootdata_req   = (state_q == ST_REQ);
  assign host_bootdata_reset = (state_q == ST_RST);
  assign host_bootdata_size  = size_q;
  assign loadchr             = chr_q;
  assign busy  = (state_q == ST_RST) || (state_q == ST_FILL) ||
                 (state_q == ST_REQ) || (state_q == ST_ACKLO);
  assign done  = (state_q == ST_DONE);
  assign error = (state_q == ST_ERR);

`ifdef BOOT_FEEDER_CHECKSUM_EN
  logic [15:0] sum_q, sum_d;

  always_comb begin
    sum_d = sum_q;
    if (pk_clear) begin
      sum_d = 16'd0;
    end else if (pk_push) begin
      sum_d = sum_q + {8'h00, in_data};
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sum_q <= 16'd0;
    end else begin
      sum_q <= sum_d;
    end
  end

  assign checksum = sum_q;
`endif

endmodule

// File: tb/tb_boot_word_feeder.sv
// tb/tb_boot_word_feeder.sv - scoreboard bench for boot_word_feeder with a loader model
module tb_boot_word_feeder;

  localparam int RST_CYC = 4;
  localparam int TMO     = 40;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        start = 1'b0;
  logic [15:0] start_size = 16'd0;
  logic        start_chr = 1'b0;
  logic [7:0]  in_data = 8'd0;
  logic        in_valid = 1'b0;
  logic        in_ready;
  logic [31:0] host_bootdata;
  logic        host_bootdata_req;
  logic        host_bootdata_ack = 1'b0;
  logic        host_bootdata_reset;
  logic [15:0] host_bootdata_size;
  logic        loadchr;
  logic        busy;
  logic        done;
  logic        error;
`ifdef BOOT_FEEDER_CHECKSUM_EN
  logic [15:0] checksum;
`endif

  always #5 clk = ~clk;

  boot_word_feeder #(.RST_CYCLES(RST_CYC), .PAD_BYTE(8'hFF), .ACK_TMO(TMO)) dut (
    .clk                 (clk),
    .rst_n               (rst_n),
    .start               (start),
    .start_size          (start_size),
    .start_chr           (start_chr),
    .in_data             (in_data),
    .in_valid            (in_valid),
    .in_ready            (in_ready),
    .host_bootdata       (host_bootdata),
    .host_bootdata_req   (host_bootdata_req),
    .host_bootdata_ack   (host_bootdata_ack),
    .host_bootdata_reset (host_bootdata_reset),
    .host_bootdata_size  (host_bootdata_size),
    .loadchr             (loadchr),
    .busy                (busy),
    .done                (done),
    .error               (error)
`ifdef BOOT_FEEDER_CHECKSUM_EN
    ,.checksum           (checksum)
`endif
  );

  int          n_vec = 0;
  int          n_err = 0;
  logic [31:0] sb[$];
  logic [7:0]  src[$];
  logic        loader_en = 1'b1;
  logic        stuck = 1'b0;
  int          req_count = 0;
  int          rdy_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  always @(negedge clk) if (in_ready) rdy_cnt++;

  // Loader model: consumes words from the scoreboard and answers with ack.
  initial begin
    logic [31:0] w;
    int t;
    int hold;
    forever begin
      @(negedge clk);
      if (loader_en && rst_n && host_bootdata_req) begin
        w = host_bootdata;
        if (sb.size() == 0) begin
          n_vec++;
          n_err++;
          $display("FAIL unexpected word: got %h expected none", w);
        end else begin
          check("word", w, sb.pop_front());
        end
        req_count++;
        repeat ($urandom_range(0, 3)) begin
          @(negedge clk);
          if (host_bootdata_req) check("word stable", host_bootdata, w);
        end
        host_bootdata_ack = 1'b1;
        t = 0;
        while (host_bootdata_req && t < 50) begin
          @(negedge clk);
          t++;
        end
        check("req drop after ack", 32'(host_bootdata_req), 32'd0);
        hold = stuck ? 5 : int'($urandom_range(0, 2));
        repeat (hold) begin
          @(negedge clk);
          check("req while ack high", 32'(host_bootdata_req), 32'd0);
        end
        host_bootdata_ack = 1'b0;
      end
    end
  end

  task automatic start_xfer(input int size, input logic chr);
    int rst_w;
    int t;
    start      = 1'b1;
    start_size = 16'(size);
    start_chr  = chr;
    @(negedge clk);
    start = 1'b0;
    rst_w = 0;
    t = 0;
    while (host_bootdata_reset && t < 100) begin
      rst_w++;
      @(negedge clk);
      t++;
    end
    check("reset width", 32'(rst_w), 32'(RST_CYC));
  endtask

  task automatic feed_bytes(input int n, input logic gaps, input logic poke_start);
    logic ok;
    int t;
    for (int i = 0; i < n; i++) begin
      if (gaps) begin
        in_valid = 1'b0;
        repeat ($urandom_range(0, 3)) @(negedge clk);
      end
      in_valid = 1'b1;
      in_data  = src[i];
      if (poke_start && i == 1) begin
        start      = 1'b1;
        start_size = 16'hABCD;
      end
      t = 0;
      do begin
        ok = in_ready;
        @(negedge clk);
        t++;
      end while (!ok && t < 500);
      start = 1'b0;
      if (!ok) begin
        check("in_ready timeout", 32'(ok), 32'd1);
        break;
      end
    end
    in_valid = 1'b0;
  endtask

  task automatic run_xfer(input int size, input logic chr, input logic gaps);
    int words;
    int rc0;
    int rdy0;
    int t;
    int idx;
    logic [31:0] word;
    logic [7:0]  b;
    logic [15:0] sum;
    words = (size + 3) / 4;
    sum = 16'd0;
    for (int w = 0; w < words; w++) begin
      word = 32'h0;
      for (int k = 0; k < 4; k++) begin
        idx = 4 * w + k;
        b = (idx < size) ? src[idx] : 8'hFF;
        word = {word[23:0], b};
      end
      sb.push_back(word);
    end
    for (int i = 0; i < size; i++) sum = sum + 16'(src[i]);
    rc0  = req_count;
    rdy0 = rdy_cnt;
    start_xfer(size, chr);
    check("size latched", 32'(host_bootdata_size), 32'(size));
    check("loadchr latched", 32'(loadchr), 32'(chr));
    feed_bytes(size, gaps, gaps);
    t = 0;
    while (!done && !error && t < 2000) begin
      @(negedge clk);
      t++;
    end
    repeat (2) @(negedge clk);
    check("done", 32'(done), 32'd1);
    check("error", 32'(error), 32'd0);
    check("busy after done", 32'(busy), 32'd0);
    check("size stable", 32'(host_bootdata_size), 32'(size));
    check("word count", 32'(req_count - rc0), 32'(words));
    check("scoreboard empty", 32'(sb.size()), 32'd0);
    if (size == 0) check("in_ready never high", 32'(rdy_cnt - rdy0), 32'd0);
`ifdef BOOT_FEEDER_CHECKSUM_EN
    check("checksum", 32'(checksum), 32'(sum));
`endif
    sb.delete();
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, " req"}, 32'(host_bootdata_req), 32'd0);
    check({tag, " reset"}, 32'(host_bootdata_reset), 32'd0);
    check({tag, " in_ready"}, 32'(in_ready), 32'd0);
    check({tag, " busy"}, 32'(busy), 32'd0);
    check({tag, " done"}, 32'(done), 32'd0);
    check({tag, " error"}, 32'(error), 32'd0);
    check({tag, " data"}, host_bootdata, 32'd0);
    check({tag, " size"}, 32'(host_bootdata_size), 32'd0);
    check({tag, " loadchr"}, 32'(loadchr), 32'd0);
  endtask

  initial begin
    int cnt;
    int t;
    int sz;
    repeat (3) @(negedge clk);
    check_all_zero("reset");
    rst_n = 1'b1;
    @(negedge clk);

    src.delete();
    for (int i = 1; i <= 8; i++) src.push_back(8'(i));
    run_xfer(8, 1'b0, 1'b0);

    src.delete();
    src.push_back(8'hAA); src.push_back(8'hBB); src.push_back(8'hCC);
    src.push_back(8'hDD); src.push_back(8'hEE);
    run_xfer(5, 1'b1, 1'b0);

    src.delete();
    run_xfer(0, 1'b0, 1'b0);

    // Loader silent: request must time out.
    loader_en = 1'b0;
    src.delete();
    for (int i = 0; i < 4; i++) src.push_back(8'($urandom));
    start_xfer(4, 1'b0);
    feed_bytes(4, 1'b0, 1'b0);
    t = 0;
    while (!host_bootdata_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    cnt = 0;
    while (host_bootdata_req && cnt < 200) begin
      cnt++;
      @(negedge clk);
    end
    check("req cycles before timeout", 32'(cnt), 32'(TMO));
    check("timeout error", 32'(error), 32'd1);
    check("timeout done", 32'(done), 32'd0);
    check("timeout busy", 32'(busy), 32'd0);
    loader_en = 1'b1;
    run_xfer(4, 1'b0, 1'b0);

    for (int n = 0; n < 12; n++) begin
      sz = int'($urandom_range(1, 24));
      stuck = 1'($urandom_range(0, 1));
      src.delete();
      for (int i = 0; i < sz; i++) src.push_back(8'($urandom));
      run_xfer(sz, 1'($urandom_range(0, 1)), 1'b1);
    end
    stuck = 1'b0;

    // Reset in the middle of FILL.
    src.delete();
    for (int i = 0; i < 8; i++) src.push_back(8'($urandom));
    start_xfer(8, 1'b1);
    feed_bytes(2, 1'b0, 1'b0);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst mid-fill");
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);

    // Reset while a word is being requested.
    loader_en = 1'b0;
    start_xfer(4, 1'b1);
    feed_bytes(4, 1'b0, 1'b0);
    t = 0;
    while (!host_bootdata_req && t < 50) begin
      @(negedge clk);
      t++;
    end
    check("req before reset", 32'(host_bootdata_req), 32'd1);
    rst_n = 1'b0;
    #1;
    check_all_zero("rst mid-req");
    @(negedge clk);
    rst_n = 1'b1;
    loader_en = 1'b1;
    @(negedge clk);
    src.delete();
    for (int i = 0; i < 7; i++) src.push_back(8'($urandom));
    run_xfer(7, 1'b1, 1'b1);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL global timeout: got running expected finished");
    $fatal(1);
  end

endmodule
